// File: rtl/fetch_pc_stage.sv
// PC register and instruction-fetch stage: next-PC select, IM wait-state handling
// and the IF/ID pipeline register (hold on stall, bubble on redirect).
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  branch_ctrl,
    input  logic [31:0] pc_imm_target,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        flush_out,
    output logic        fetch_busy
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            valid;
    } if_id_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pending_pc;
    logic [XLEN-1:0] pending_next;
    if_id_t          if_id;
    if_id_t          if_id_next;
    if_id_t          bubble;
    logic            redirect;
    logic [XLEN-1:0] target;

    assign bubble = {XLEN'(0), NOP_INST, 1'b0};

    // 2'b11 is reserved and decodes as sequential fetch
    always_comb begin
        redirect = (branch_ctrl == 2'b10) || (branch_ctrl == 2'b01);
        target   = (branch_ctrl == 2'b10) ? pc_imm_target : {jalr_target[XLEN-1:1], 1'b0};
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pending_pc <= '0;
            if_id      <= bubble;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pending_pc <= pending_next;
            if_id      <= if_id_next;
        end
    end

    // Next-state logic; priority is redirect > stall > im_ready
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        pending_next = pending_pc;
        if_id_next   = if_id;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if_id_next = bubble;
                    if (im_ready) begin
                        pc_next = target;
                    end else begin
                        // old request still outstanding; park the target until it completes
                        pending_next = target;
                        state_next   = DRAIN;
                    end
                end else if (!stall) begin
                    if (im_ready) begin
                        if_id_next = {pc, im_rdata, 1'b1};
                        pc_next    = pc + XLEN'(4);
                    end else begin
                        if_id_next = bubble;
                    end
                end
            end
            DRAIN: begin
                if_id_next = bubble;
                if (redirect) begin
                    pending_next = target;
                end
                if (im_ready) begin
                    pc_next    = redirect ? target : pending_pc;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Output decode
    always_comb begin
        im_req      = !rst;
        flush_out   = redirect && !rst;
        fetch_busy  = (state == DRAIN);
        im_addr     = pc;
        if_id_pc    = if_id.pc;
        if_id_inst  = if_id.inst;
        if_id_valid = if_id.valid;
    end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage; instruction memory returns im_addr + 0x93.
module tb_fetch_pc_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  branch_ctrl;
    logic [31:0] pc_imm_target;
    logic [31:0] jalr_target;
    logic        stall;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        flush_out;
    logic        fetch_busy;

    int tests = 0;
    int fails = 0;

    fetch_pc_stage dut (
        .clk          (clk),
        .rst          (rst),
        .branch_ctrl  (branch_ctrl),
        .pc_imm_target(pc_imm_target),
        .jalr_target  (jalr_target),
        .stall        (stall),
        .im_req       (im_req),
        .im_addr      (im_addr),
        .im_ready     (im_ready),
        .im_rdata     (im_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_inst   (if_id_inst),
        .if_id_valid  (if_id_valid),
        .flush_out    (flush_out),
        .fetch_busy   (fetch_busy)
    );

    always #5 clk = ~clk;

    assign im_rdata = im_addr + 32'h0000_0093;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic valid);
        chk({tag, ".pc"}, if_id_pc, pc);
        chk({tag, ".inst"}, if_id_inst, inst);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
    endtask

    initial begin
        rst = 1'b1; branch_ctrl = 2'b10; pc_imm_target = 32'h40; jalr_target = 32'h0;
        stall = 1'b0; im_ready = 1'b0;
        tick(); tick();
        chk("rst_im_req", 32'(im_req), 32'h0);
        chk("rst_flush", 32'(flush_out), 32'h0);
        chk("rst_addr", im_addr, 32'h0);
        chk("rst_busy", 32'(fetch_busy), 32'h0);
        chk_ifid("rst_ifid", 32'h0, 32'h13, 1'b0);

        // sequential fetch
        rst = 1'b0; branch_ctrl = 2'b00; im_ready = 1'b1; #1;
        chk("seq_im_req", 32'(im_req), 32'h1);
        chk("seq_addr0", im_addr, 32'h0);
        tick();
        chk("seq_addr4", im_addr, 32'h4);
        chk_ifid("seq_if0", 32'h0, 32'h93, 1'b1);
        chk("seq_flush", 32'(flush_out), 32'h0);
        tick();
        chk("seq_addr8", im_addr, 32'h8);
        chk_ifid("seq_if4", 32'h4, 32'h97, 1'b1);
        tick(); tick();
        chk("seq_addr10", im_addr, 32'h10);

        // branch redirect with im_ready
        branch_ctrl = 2'b10; pc_imm_target = 32'h40; #1;
        chk("br_flush", 32'(flush_out), 32'h1);
        tick();
        branch_ctrl = 2'b00; #1;
        chk("br_addr", im_addr, 32'h40);
        chk_ifid("br_bubble", 32'h0, 32'h13, 1'b0);
        chk("br_flush_off", 32'(flush_out), 32'h0);
        tick();
        chk("br_addr44", im_addr, 32'h44);
        chk_ifid("br_if40", 32'h40, 32'hD3, 1'b1);

        // JALR clears bit 0
        branch_ctrl = 2'b01; jalr_target = 32'h0000_0101; #1;
        chk("jalr_flush", 32'(flush_out), 32'h1);
        tick();
        branch_ctrl = 2'b00;
        chk("jalr_addr", im_addr, 32'h100);
        chk_ifid("jalr_bubble", 32'h0, 32'h13, 1'b0);

        // stall at pc 0x20 with IF/ID holding 0x1C
        branch_ctrl = 2'b10; pc_imm_target = 32'h1C; tick();
        branch_ctrl = 2'b00; tick();
        chk("st_pre_addr", im_addr, 32'h20);
        chk_ifid("st_pre", 32'h1C, 32'hAF, 1'b1);
        stall = 1'b1;
        tick();
        chk("st_addr1", im_addr, 32'h20);
        chk_ifid("st_hold1", 32'h1C, 32'hAF, 1'b1);
        tick();
        chk("st_addr2", im_addr, 32'h20);
        chk_ifid("st_hold2", 32'h1C, 32'hAF, 1'b1);
        stall = 1'b0;
        tick();
        chk("st_rel_addr", im_addr, 32'h24);
        chk_ifid("st_rel", 32'h20, 32'hB3, 1'b1);

        // redirect during IM wait goes through DRAIN
        branch_ctrl = 2'b10; pc_imm_target = 32'h30; tick();
        chk("dr_pre_addr", im_addr, 32'h30);
        im_ready = 1'b0; pc_imm_target = 32'h80; #1;
        chk("dr_flush", 32'(flush_out), 32'h1);
        tick();
        branch_ctrl = 2'b00;
        chk("dr_busy1", 32'(fetch_busy), 32'h1);
        chk("dr_addr1", im_addr, 32'h30);
        chk_ifid("dr_bub1", 32'h0, 32'h13, 1'b0);
        stall = 1'b1;
        tick();
        chk("dr_busy2", 32'(fetch_busy), 32'h1);
        chk("dr_addr2", im_addr, 32'h30);
        chk_ifid("dr_bub2", 32'h0, 32'h13, 1'b0);
        stall = 1'b0; im_ready = 1'b1;
        tick();
        chk("dr_done_addr", im_addr, 32'h80);
        chk("dr_done_busy", 32'(fetch_busy), 32'h0);
        chk_ifid("dr_done_bub", 32'h0, 32'h13, 1'b0);
        tick();
        chk("dr_next_addr", im_addr, 32'h84);
        chk_ifid("dr_if80", 32'h80, 32'h113, 1'b1);

        // IM wait in FETCH: bubbles, pc holds
        im_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_addr", im_addr, 32'h84);
            chk("wait_valid", 32'(if_id_valid), 32'h0);
            chk("wait_inst", if_id_inst, 32'h13);
        end
        im_ready = 1'b1;
        tick();
        chk("wait_rel_addr", im_addr, 32'h88);
        chk_ifid("wait_if84", 32'h84, 32'h117, 1'b1);

        // wrap at top of address space
        branch_ctrl = 2'b10; pc_imm_target = 32'hFFFF_FFFC; tick();
        branch_ctrl = 2'b00;
        chk("wrap_pre", im_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", im_addr, 32'h0);
        chk_ifid("wrap_if", 32'hFFFF_FFFC, 32'h0000_008F, 1'b1);

        // reserved branch_ctrl behaves as sequential
        branch_ctrl = 2'b11; pc_imm_target = 32'h500; jalr_target = 32'h600; #1;
        chk("rsv_flush", 32'(flush_out), 32'h0);
        tick();
        chk("rsv_addr", im_addr, 32'h4);
        chk_ifid("rsv_if", 32'h0, 32'h93, 1'b1);

        // misaligned branch target passes through
        branch_ctrl = 2'b10; pc_imm_target = 32'h0000_0702; tick();
        branch_ctrl = 2'b00;
        chk("mis_addr", im_addr, 32'h702);

        // reset while draining
        im_ready = 1'b0; branch_ctrl = 2'b10; pc_imm_target = 32'h900; tick();
        branch_ctrl = 2'b00;
        chk("rd_busy", 32'(fetch_busy), 32'h1);
        rst = 1'b1; #1;
        chk("rd_im_req", 32'(im_req), 32'h0);
        tick();
        rst = 1'b0; im_ready = 1'b1; #1;
        chk("rd_addr", im_addr, 32'h0);
        chk("rd_busy_off", 32'(fetch_busy), 32'h0);
        chk("rd_valid", 32'(if_id_valid), 32'h0);
        tick();
        chk("rd_next_addr", im_addr, 32'h4);
        chk_ifid("rd_if0", 32'h0, 32'h93, 1'b1);

        // latest redirect in DRAIN wins
        im_ready = 1'b0; branch_ctrl = 2'b10; pc_imm_target = 32'h300; tick();
        branch_ctrl = 2'b01; jalr_target = 32'h0000_0401; tick();
        chk("lw_busy", 32'(fetch_busy), 32'h1);
        chk("lw_addr_hold", im_addr, 32'h4);
        branch_ctrl = 2'b00; im_ready = 1'b1; tick();
        chk("lw_addr", im_addr, 32'h400);
        chk("lw_busy_off", 32'(fetch_busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
